tile_raster_tracker: RTL and testbench

- Upstream stage of the per-tile renderer. Converts global VGA raster counts into a 4x4 board location.
- Outputs tile-local h/v counts (0..TILE_SIZE-1), the 4-bit tile state and an in-tile flag. These feed the tile renderer's state/h_cnt/v_cnt inputs.
- Uses incremental counters, not dividers. Holds a per-frame snapshot of the board so a move mid-frame cannot tear the display.

---
 rtl/tile_raster_tracker.sv | 172 +++++++++++++++++
 tb/tb_tile_raster_tracker.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_raster_tracker.sv
// Maps global VGA raster counts onto a 4x4 tile board using incremental trackers.
// Define TILE_SNAPSHOT_EN to read tile states from a frame-start board snapshot.
module tile_raster_tracker #(
  parameter logic [11:0] BOARD_X0  = 12'd100,
  parameter logic [11:0] BOARD_Y0  = 12'd20,
  parameter logic [11:0] TILE_SIZE = 12'd106,
  parameter logic [11:0] GAP       = 12'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] h_cnt,
  input  logic [11:0] v_cnt,
  input  logic [63:0] board_state,
  output logic [11:0] tile_h_cnt,
  output logic [11:0] tile_v_cnt,
  output logic [3:0]  tile_state,
  output logic [3:0]  tile_index,
  output logic        in_tile
);

  localparam logic [11:0] TILE_LAST = TILE_SIZE - 12'd1;
  localparam logic [11:0] GAP_LAST  = GAP - 12'd1;

  typedef enum logic [1:0] {H_IDLE, H_TILE, H_GAP} h_state_t;
  typedef enum logic [1:0] {V_IDLE, V_TILE, V_GAP} v_state_t;

  h_state_t    h_state, h_state_n, h_cur;
  logic [11:0] h_loc, h_loc_n, h_gcnt, h_gcnt_n;
  logic [1:0]  col, col_n;

  v_state_t    v_state, v_state_n, v_cur;
  logic [11:0] v_loc, v_loc_n, v_gcnt, v_gcnt_n;
  logic [1:0]  row, row_n;

  logic        in_n;
  logic [3:0]  idx_n;
  logic [63:0] state_src;

`ifdef TILE_SNAPSHOT_EN
  logic [63:0] snap, snap_n;
  assign snap_n    = (h_cnt == '0 && v_cnt == '0) ? board_state : snap;
  assign state_src = snap_n;
`else
  assign state_src = board_state;
`endif

  // Line start forces idle first; the entry check then runs on the forced state.
  always_comb begin
    h_state_n = h_state;
    h_loc_n   = h_loc;
    h_gcnt_n  = h_gcnt;
    col_n     = col;
    h_cur     = (h_cnt == '0) ? H_IDLE : h_state;
    case (h_cur)
      H_IDLE: begin
        h_state_n = H_IDLE;
        if (h_cnt == BOARD_X0) begin
          h_state_n = H_TILE;
          h_loc_n   = '0;
          col_n     = '0;
        end
      end
      H_TILE: begin
        if (h_loc == TILE_LAST) begin
          if (col == 2'd3) begin
            h_state_n = H_IDLE;
          end else begin
            h_state_n = H_GAP;
            h_gcnt_n  = '0;
          end
        end else begin
          h_loc_n = h_loc + 12'd1;
        end
      end
      H_GAP: begin
        if (h_gcnt == GAP_LAST) begin
          h_state_n = H_TILE;
          col_n     = col + 2'd1;
          h_loc_n   = '0;
        end else begin
          h_gcnt_n = h_gcnt + 12'd1;
        end
      end
      default: h_state_n = H_IDLE;
    endcase
  end

  // Vertical tracker advances once per line, on the h_cnt==0 clock.
  always_comb begin
    v_state_n = v_state;
    v_loc_n   = v_loc;
    v_gcnt_n  = v_gcnt;
    row_n     = row;
    v_cur     = (v_cnt == '0) ? V_IDLE : v_state;
    if (h_cnt == '0) begin
      case (v_cur)
        V_IDLE: begin
          v_state_n = V_IDLE;
          if (v_cnt == BOARD_Y0) begin
            v_state_n = V_TILE;
            v_loc_n   = '0;
            row_n     = '0;
          end
        end
        V_TILE: begin
          if (v_loc == TILE_LAST) begin
            if (row == 2'd3) begin
              v_state_n = V_IDLE;
            end else begin
              v_state_n = V_GAP;
              v_gcnt_n  = '0;
            end
          end else begin
            v_loc_n = v_loc + 12'd1;
          end
        end
        V_GAP: begin
          if (v_gcnt == GAP_LAST) begin
            v_state_n = V_TILE;
            row_n     = row + 2'd1;
            v_loc_n   = '0;
          end else begin
            v_gcnt_n = v_gcnt + 12'd1;
          end
        end
        default: v_state_n = V_IDLE;
      endcase
    end
  end

  assign in_n  = (h_state_n == H_TILE) && (v_state_n == V_TILE);
  assign idx_n = {row_n, col_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      h_state    <= H_IDLE;
      h_loc      <= '0;
      h_gcnt     <= '0;
      col        <= '0;
      v_state    <= V_IDLE;
      v_loc      <= '0;
      v_gcnt     <= '0;
      row        <= '0;
      tile_h_cnt <= '0;
      tile_v_cnt <= '0;
      tile_state <= '0;
      tile_index <= '0;
      in_tile    <= 1'b0;
`ifdef TILE_SNAPSHOT_EN
      snap       <= '0;
`endif
    end else begin
      h_state    <= h_state_n;
      h_loc      <= h_loc_n;
      h_gcnt     <= h_gcnt_n;
      col        <= col_n;
      v_state    <= v_state_n;
      v_loc      <= v_loc_n;
      v_gcnt     <= v_gcnt_n;
      row        <= row_n;
      in_tile    <= in_n;
      tile_h_cnt <= in_n ? h_loc_n : '0;
      tile_v_cnt <= in_n ? v_loc_n : '0;
      tile_index <= in_n ? idx_n : '0;
      tile_state <= in_n ? state_src[{idx_n, 2'b00} +: 4] : '0;
`ifdef TILE_SNAPSHOT_EN
      snap       <= snap_n;
`endif
    end
  end

endmodule

// File: tb/tb_tile_raster_tracker.sv
// Self-checking bench for tile_raster_tracker: raster sweeps against a
// coordinate-arithmetic reference model (honours TILE_SNAPSHOT_EN).
module tb_tile_raster_tracker;

  localparam int X0 = 100;
  localparam int Y0 = 20;
  localparam int TS = 106;
  localparam int GP = 8;

  typedef struct packed {
    logic        in;
    logic [11:0] th;
    logic [11:0] tv;
    logic [3:0]  ts;
    logic [3:0]  ti;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] h_cnt, v_cnt;
  logic [63:0] board;
  logic [11:0] tile_h_cnt, tile_v_cnt;
  logic [3:0]  tile_state, tile_index;
  logic        in_tile;

  int checks = 0;
  int failures = 0;

  // Reference model state: tracking-enabled flags and the frame snapshot.
  bit          hflag, vflag;
  logic [63:0] snap;

  tile_raster_tracker #(
    .BOARD_X0(12'd100), .BOARD_Y0(12'd20), .TILE_SIZE(12'd106), .GAP(12'd8)
  ) dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .board_state(board),
    .tile_h_cnt(tile_h_cnt), .tile_v_cnt(tile_v_cnt), .tile_state(tile_state),
    .tile_index(tile_index), .in_tile(in_tile)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL timeout: run exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  function automatic out_t model(input int h, input int v);
    out_t e;
    int pitch, span, dx, dy, c, r;
    e = '0;
    pitch = TS + GP;
    span  = 4 * pitch - GP;
    dx = h - X0;
    dy = v - Y0;
    if (hflag && vflag && dx >= 0 && dx < span && dy >= 0 && dy < span &&
        (dx % pitch) < TS && (dy % pitch) < TS) begin
      c = dx / pitch;
      r = dy / pitch;
      e.in = 1'b1;
      e.th = 12'(dx % pitch);
      e.tv = 12'(dy % pitch);
      e.ti = 4'(r * 4 + c);
`ifdef TILE_SNAPSHOT_EN
      e.ts = snap[4 * (r * 4 + c) +: 4];
`else
      e.ts = board[4 * (r * 4 + c) +: 4];
`endif
    end
    return e;
  endfunction

  // Presents one pixel, advances the model, and returns expected/observed outputs.
  task automatic pixel(input int h, input int v, input logic r, output out_t e, output out_t o);
    h_cnt = 12'(h);
    v_cnt = 12'(v);
    rst   = r;
    if (r) begin
      hflag = 0; vflag = 0; snap = '0; e = '0;
    end else begin
      if (h == X0) hflag = 1;
      if (h == 0 && v == Y0) vflag = 1;
      if (h == 0 && v == 0) snap = board;
      e = model(h, v);
    end
    @(posedge clk);
    #1;
    o = {in_tile, tile_h_cnt, tile_v_cnt, tile_state, tile_index};
  endtask

  // One-pixel lines used to walk the vertical raster quickly.
  task automatic skip_lines(input int v0, input int v1);
    out_t e, o;
    for (int v = v0; v <= v1; v++) pixel(0, v, 1'b0, e, o);
  endtask

  task automatic test_reset();
    out_t e, o;
    board = 64'h0000_0000_0005_4321;
    for (int i = 0; i < 3; i++) begin
      pixel(150, 50, 1'b1, e, o);
      checks++;
      if (o !== '0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=0", i, o);
      end
    end
    pixel(150, 50, 1'b0, e, o);
    checks++;
    if (o !== '0) begin
      failures++;
      $display("FAIL reset_release got=%h exp=0", o);
    end
  endtask

  task automatic test_line_sweep();
    out_t e, o, o100, o205, o206, o214, o442, o548;
    board = 64'h0000_0000_0005_4321;
    skip_lines(0, 19);
    for (int h = 0; h <= 700; h++) begin
      pixel(h, 20, 1'b0, e, o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL sweep v=20 h=%0d got=%h exp=%h", h, o, e);
      end
      if (h == 100) o100 = o;
      if (h == 205) o205 = o;
      if (h == 206) o206 = o;
      if (h == 214) o214 = o;
      if (h == 442) o442 = o;
      if (h == 548) o548 = o;
    end
    checks += 6;
    if (o100 !== {1'b1, 12'd0, 12'd0, 4'd1, 4'd0}) begin failures++; $display("FAIL first_pixel got=%h", o100); end
    if (o205 !== {1'b1, 12'd105, 12'd0, 4'd1, 4'd0}) begin failures++; $display("FAIL last_pixel_col0 got=%h", o205); end
    if (o206 !== '0) begin failures++; $display("FAIL gap_start got=%h exp=0", o206); end
    if (o214 !== {1'b1, 12'd0, 12'd0, 4'd2, 4'd1}) begin failures++; $display("FAIL col1_entry got=%h", o214); end
    if (o442 !== {1'b1, 12'd0, 12'd0, 4'd4, 4'd3}) begin failures++; $display("FAIL col3_entry got=%h", o442); end
    if (o548 !== '0) begin failures++; $display("FAIL past_board got=%h exp=0", o548); end
  endtask

  task automatic test_vertical_boundaries();
    out_t e, o, o125, o134;
    bit any_gap_in;
    any_gap_in = 0;
    skip_lines(21, 124);
    for (int v = 125; v <= 134; v++) begin
      for (int h = 0; h < 600; h++) begin
        pixel(h, v, 1'b0, e, o);
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL vsweep v=%0d h=%0d got=%h exp=%h", v, h, o, e);
        end
        if (v == 125 && h == 100) o125 = o;
        if (v == 134 && h == 100) o134 = o;
        if (v >= 126 && v <= 133 && o.in) any_gap_in = 1;
      end
    end
    checks += 3;
    if (o125 !== {1'b1, 12'd0, 12'd105, 4'd1, 4'd0}) begin failures++; $display("FAIL row0_last got=%h", o125); end
    if (any_gap_in !== 1'b0) begin failures++; $display("FAIL vgap_in_tile got=%0d exp=0", any_gap_in); end
    if (o134 !== {1'b1, 12'd0, 12'd0, 4'd5, 4'd4}) begin failures++; $display("FAIL row1_entry got=%h", o134); end
    skip_lines(135, 524);
  endtask

  task automatic test_snapshot();
    out_t e, o, old_f, new_f;
    board = 64'h1111_2222_3333_4444;
    skip_lines(0, 249);
    for (int f = 0; f < 2; f++) begin
      if (f == 1) skip_lines(0, 319);
      for (int h = 0; h < 600; h++) begin
        pixel(h, (f == 0) ? 250 : 320, 1'b0, e, o);
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL snap_line f=%0d h=%0d got=%h exp=%h", f, h, o, e);
        end
        if (f == 1 && h == 100) new_f = o;
      end
      if (f == 0) begin
        skip_lines(251, 299);
        board = {16{4'hB}};
        skip_lines(300, 319);
        for (int h = 0; h < 600; h++) begin
          pixel(h, 320, 1'b0, e, o);
          checks++;
          if (o !== e) begin
            failures++;
            $display("FAIL snap_change h=%0d got=%h exp=%h", h, o, e);
          end
          if (h == 100) old_f = o;
        end
        skip_lines(321, 524);
      end
    end
    skip_lines(321, 524);
    checks += 2;
`ifdef TILE_SNAPSHOT_EN
    if (old_f.ts !== 4'd2 || old_f.ti !== 4'd8) begin failures++; $display("FAIL snap_hold got=%h exp_ts=2", old_f); end
`else
    if (old_f.ts !== 4'hB || old_f.ti !== 4'd8) begin failures++; $display("FAIL live_state got=%h exp_ts=b", old_f); end
`endif
    if (new_f.ts !== 4'hB || new_f.in !== 1'b1) begin failures++; $display("FAIL next_frame got=%h exp_ts=b", new_f); end
  endtask

  task automatic test_reset_midframe();
    out_t e, o, o250, o20;
    board = {16{4'hA, 4'h5}};
    skip_lines(0, 199);
    for (int h = 0; h < 600; h++) begin
      pixel(h, 200, (h == 300) ? 1'b1 : 1'b0, e, o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rst_line h=%0d got=%h exp=%h", h, o, e);
      end
    end
    skip_lines(201, 249);
    for (int h = 0; h < 600; h++) begin
      pixel(h, 250, 1'b0, e, o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL post_rst h=%0d got=%h exp=%h", h, o, e);
      end
      if (h == 100) o250 = o;
    end
    skip_lines(251, 524);
    skip_lines(0, 19);
    for (int h = 0; h < 600; h++) begin
      pixel(h, 20, 1'b0, e, o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL resume h=%0d got=%h exp=%h", h, o, e);
      end
      if (h == 100) o20 = o;
    end
    skip_lines(21, 524);
    checks += 2;
    if (o250 !== '0) begin failures++; $display("FAIL idle_after_rst got=%h exp=0", o250); end
    if (o20 !== {1'b1, 12'd0, 12'd0, 4'd5, 4'd0}) begin failures++; $display("FAIL resume_entry got=%h", o20); end
  endtask

  task automatic test_random_frames();
    out_t e, o;
    int len;
    for (int f = 0; f < 2; f++) begin
      for (int v = 0; v < 525; v++) begin
        if ($urandom_range(0, 7) == 0) board = {$urandom, $urandom};
        if (v == 20 || v == 125 || v == 126 || v == 134 || v == 467 || v == 468)
          len = 600;
        else if ($urandom_range(0, 31) == 0)
          len = $urandom_range(1, 700);
        else
          len = 1;
        for (int h = 0; h < len; h++) begin
          pixel(h, v, 1'b0, e, o);
          checks++;
          if (o !== e) begin
            failures++;
            $display("FAIL random f=%0d v=%0d h=%0d got=%h exp=%h", f, v, h, o, e);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    h_cnt = '0;
    v_cnt = '0;
    board = '0;
    hflag = 0;
    vflag = 0;
    snap = '0;
    #2;
    test_reset();
    test_line_sweep();
    test_vertical_boundaries();
    test_snapshot();
    test_reset_midframe();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
